// File: rtl/sync_fifo_pkg.sv
// Configuration shared between the synchronous FIFO buffer and its stream-side adapter.
package sync_fifo_pkg;

  typedef enum int unsigned {
    FWFT_LAT = 0,
    STD_LAT  = 1
  } read_latency_t;

  localparam int unsigned OUT_BUF_DEPTH = 2;
  localparam int unsigned OUT_PTR_W     = $clog2(OUT_BUF_DEPTH);
  localparam int unsigned OUT_CNT_W     = $clog2(OUT_BUF_DEPTH + 1);

endpackage

// File: rtl/sync_fifo_stream_adapter_if.sv
// FIFO read port plus valid/ready stream; master is the adapter, slave is FIFO + sink.
interface sync_fifo_stream_adapter_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  fifo_empty_i;
  logic                  fifo_read_o;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [OUT_CNT_W-1:0]  count_o;

  modport master (
    input  fifo_empty_i, fifo_rd_data_i, m_ready_i,
    output fifo_read_o, m_valid_o, m_data_o, count_o
  );

  modport slave (
    output fifo_empty_i, fifo_rd_data_i, m_ready_i,
    input  fifo_read_o, m_valid_o, m_data_o, count_o
  );

endinterface

// File: rtl/fifo_stream_buf2.sv
// Two-entry circular output buffer: push at tail, pop at head, registered head data.
module fifo_stream_buf2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [OUT_CNT_W-1:0]  count_o
);

  logic [DATA_WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
  logic [OUT_PTR_W-1:0]  head_q, head_d;
  logic [OUT_PTR_W-1:0]  tail_q, tail_d;
  logic [OUT_CNT_W-1:0]  count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + OUT_PTR_W'(1);
    if (pop_i)  head_d = head_q + OUT_PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + OUT_CNT_W'(1);
      2'b01:   count_d = count_q - OUT_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear leaves storage alone; only reset has to zero the visible head data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < OUT_BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[tail_q] <= push_data_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (count_q <= OUT_CNT_W'(OUT_BUF_DEPTH));
  end

  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/sync_fifo_stream_adapter.sv
// Turns a FIFO read port (FWFT or 1-cycle latency) into a registered valid/ready stream.
module sync_fifo_stream_adapter
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  sync_fifo_stream_adapter_if.master  bus
);

  localparam logic [OUT_CNT_W:0] DEPTH_L = (OUT_CNT_W + 1)'(OUT_BUF_DEPTH);

  if (READ_LATENCY != FWFT_LAT && READ_LATENCY != STD_LAT) begin : g_bad_latency
    $error("sync_fifo_stream_adapter: READ_LATENCY must be 0 or 1");
  end

  logic                  m_valid;
  logic                  pop;
  logic                  capture;
  logic                  inflight_q;
  logic                  fifo_read;
  logic [OUT_CNT_W:0]    occupancy;
  logic [OUT_CNT_W-1:0]  count;
  logic [DATA_WIDTH-1:0] head_data;

  assign m_valid = (count != '0);
  assign pop     = m_valid & bus.m_ready_i;

  // Counting this cycle's pop as free space keeps one word per cycle under ready.
  always_comb begin
    occupancy = {1'b0, count} + {{OUT_CNT_W{1'b0}}, inflight_q} - {{OUT_CNT_W{1'b0}}, pop};
    fifo_read = !rst_i && !flush_i && !bus.fifo_empty_i && (occupancy < DEPTH_L);
  end

  if (READ_LATENCY == STD_LAT) begin : g_std
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) inflight_q <= 1'b0;
      else                  inflight_q <= fifo_read;
    end
    assign capture = inflight_q;
  end else begin : g_fwft
    assign inflight_q = 1'b0;
    assign capture    = fifo_read;
  end

  fifo_stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (flush_i),
    .push_i      (capture),
    .push_data_i (bus.fifo_rd_data_i),
    .pop_i       (pop),
    .head_data_o (head_data),
    .count_o     (count)
  );

  assign bus.fifo_read_o = fifo_read;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_data_o    = head_data;
  assign bus.count_o     = count;

endmodule

// File: tb/tb_sync_fifo_stream_adapter.sv
// Drives a latency-0 and a latency-1 adapter side by side against a queue-level model.
module tb_sync_fifo_stream_adapter;
  import sync_fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned SRC_N = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush;
  logic [1:0] rdy;

  sync_fifo_stream_adapter_if #(.DATA_WIDTH(DW)) bus0 ();
  sync_fifo_stream_adapter_if #(.DATA_WIDTH(DW)) bus1 ();

  sync_fifo_stream_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus0));
  sync_fifo_stream_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus1));

  // FIFO sources: lane 0 is first-word-fall-through, lane 1 returns data one edge after the read.
  logic [DW-1:0] src [2][SRC_N];
  logic [11:0]   src_wr [2];
  logic [11:0]   src_rd [2];
  logic [DW-1:0] rdata1;

  assign bus0.fifo_empty_i   = (src_rd[0] == src_wr[0]);
  assign bus0.fifo_rd_data_i = src[0][src_rd[0]];
  assign bus0.m_ready_i      = rdy[0];
  assign bus1.fifo_empty_i   = (src_rd[1] == src_wr[1]);
  assign bus1.fifo_rd_data_i = rdata1;
  assign bus1.m_ready_i      = rdy[1];

  logic [1:0]    o_valid, o_read;
  logic [DW-1:0] o_data [2];
  logic [1:0]    o_count [2];
  assign o_valid[0] = bus0.m_valid_o;  assign o_valid[1] = bus1.m_valid_o;
  assign o_read[0]  = bus0.fifo_read_o; assign o_read[1] = bus1.fifo_read_o;
  assign o_data[0]  = bus0.m_data_o;   assign o_data[1]  = bus1.m_data_o;
  assign o_count[0] = bus0.count_o;    assign o_count[1] = bus1.count_o;

  // Model: words held by the adapter, plus one word travelling from a latency-1 FIFO.
  logic [DW-1:0] mb [2][2];
  int unsigned   mcnt [2];
  logic          mpend [2];
  logic [DW-1:0] mpend_d [2];

  int unsigned vectors, miscompares, cyc;
  int          first_rd [2], first_vld [2];
  int unsigned nrd [2], npop [2], pn [2];
  logic [DW-1:0] plog [2][64];
  int unsigned   plc [2][64];

  task automatic chk(input string nm, input int L, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d: got %h expected %h (cycle %0d)", nm, L, act, exp, cyc);
    end
  endtask

  task automatic clr_log();
    for (int L = 0; L < 2; L++) begin
      first_rd[L] = -1; first_vld[L] = -1; nrd[L] = 0; npop[L] = 0; pn[L] = 0;
    end
  endtask

  task automatic push(input int L, input logic [DW-1:0] w);
    src[L][src_wr[L]] = w;
    src_wr[L] = src_wr[L] + 12'd1;
  endtask

  // One clock: drive inputs, check against the model mid-cycle, then advance model and sources.
  task automatic step(input logic [1:0] r, input logic fl, input logic rs);
    logic rd_s [2];
    logic pop_s [2];
    rdy = r; flush = fl; rst = rs;
    @(negedge clk);
    cyc++;
    for (int L = 0; L < 2; L++) begin
      logic ev, er, emp;
      int unsigned occ;
      ev  = (mcnt[L] != 0);
      emp = (src_rd[L] == src_wr[L]);
      occ = mcnt[L] + (mpend[L] ? 1 : 0) - ((ev && r[L]) ? 1 : 0);
      er  = !rs && !fl && !emp && (occ < 2);
      chk("m_valid", L, DW'(o_valid[L]), DW'(ev));
      if (ev) chk("m_data", L, o_data[L], mb[L][0]);
      chk("count", L, DW'(o_count[L]), DW'(mcnt[L]));
      chk("fifo_read", L, DW'(o_read[L]), DW'(er));
      if (o_read[L]) begin
        nrd[L]++;
        if (first_rd[L] < 0) first_rd[L] = int'(cyc);
      end
      if (o_valid[L] && first_vld[L] < 0) first_vld[L] = int'(cyc);
      if (ev && r[L]) begin
        npop[L]++;
        if (pn[L] < 64) begin
          plog[L][pn[L]] = o_data[L];
          plc[L][pn[L]]  = cyc;
          pn[L]++;
        end
      end
      rd_s[L]  = o_read[L];
      pop_s[L] = ev && r[L];
    end
    @(posedge clk);
    for (int L = 0; L < 2; L++) begin
      logic [DW-1:0] w;
      w = src[L][src_rd[L]];
      if (rd_s[L]) begin
        src_rd[L] <= src_rd[L] + 12'd1;
        if (L == 1) rdata1 <= w;
      end
      if (rs || fl) begin
        mcnt[L]  = 0;
        mpend[L] = 1'b0;
      end else begin
        if (pop_s[L]) begin
          mb[L][0] = mb[L][1];
          mcnt[L]--;
        end
        if ((L == 0 && rd_s[L]) || (L == 1 && mpend[L])) begin
          if (mcnt[L] < 2) mb[L][mcnt[L]] = (L == 0) ? w : mpend_d[L];
          mcnt[L]++;
        end
        mpend[L]   = (L == 1) && rd_s[L];
        mpend_d[L] = w;
      end
    end
    #1;
  endtask

  function automatic logic idle(input int L);
    return (src_rd[L] == src_wr[L]) && (mcnt[L] == 0) && !mpend[L];
  endfunction

  initial begin
    int unsigned guard;
    int unsigned pushed [2];
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b1; flush = 1'b0; rdy = 2'b00; rdata1 = '0;
    for (int L = 0; L < 2; L++) begin
      src_wr[L] = '0; src_rd[L] = '0; mcnt[L] = 0; mpend[L] = 1'b0; mpend_d[L] = '0;
    end
    clr_log();
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    for (int L = 0; L < 2; L++) begin
      chk("reset_data", L, o_data[L], '0);
      chk("reset_count", L, DW'(o_count[L]), '0);
    end

    // Three preloaded words with the sink always ready.
    clr_log();
    for (int L = 0; L < 2; L++) begin
      push(L, 32'h11); push(L, 32'h22); push(L, 32'h33);
    end
    repeat (8) step(2'b11, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("first_latency", L, DW'(first_vld[L] - first_rd[L]), DW'(L + 1));
      chk("pops", L, DW'(pn[L]), 32'd3);
      chk("word0", L, plog[L][0], 32'h11);
      chk("word1", L, plog[L][1], 32'h22);
      chk("word2", L, plog[L][2], 32'h33);
      chk("back_to_back", L, DW'(plc[L][2] - plc[L][0]), 32'd2);
      chk("drained_count", L, DW'(o_count[L]), '0);
    end

    // Backpressure: five words waiting, sink stalled.
    clr_log();
    for (int L = 0; L < 2; L++) for (int i = 0; i < 5; i++) push(L, 32'h200 + i);
    repeat (6) step(2'b00, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("stall_reads", L, DW'(nrd[L]), 32'd2);
      chk("stall_count", L, DW'(o_count[L]), 32'd2);
      chk("stall_head", L, o_data[L], 32'h200);
    end
    repeat (10) step(2'b11, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("release_pops", L, DW'(pn[L]), 32'd5);
      for (int i = 0; i < 5; i++) chk("release_order", L, plog[L][i], 32'h200 + i);
    end

    // Flush with buffered data (and a word in flight on the latency-1 lane).
    clr_log();
    for (int L = 0; L < 2; L++) for (int i = 1; i <= 4; i++) push(L, 32'h300 + i);
    repeat (2) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("flush_valid", L, DW'(o_valid[L]), '0);
      chk("flush_count", L, DW'(o_count[L]), '0);
    end
    clr_log();
    repeat (8) step(2'b11, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("post_flush_pops", L, DW'(pn[L]), 32'd2);
      chk("post_flush_first", L, plog[L][0], 32'h303);
      chk("post_flush_second", L, plog[L][1], 32'h304);
    end

    // Random words and random sink readiness on both lanes.
    clr_log();
    pushed[0] = 0; pushed[1] = 0; guard = 0;
    while (guard < 20000 && !(pushed[0] == 1000 && pushed[1] == 1000 && idle(0) && idle(1))) begin
      for (int L = 0; L < 2; L++)
        if (pushed[L] < 1000 && $urandom_range(0, 2) != 0) begin
          push(L, $urandom);
          pushed[L]++;
        end
      step(2'($urandom_range(0, 3)), 1'b0, 1'b0);
      guard++;
    end
    for (int L = 0; L < 2; L++) chk("random_pops", L, DW'(npop[L]), 32'd1000);

    // Reset in the middle of streaming, then resume.
    for (int L = 0; L < 2; L++) for (int i = 0; i < 10; i++) push(L, 32'h400 + i);
    repeat (3) step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b1);
    for (int L = 0; L < 2; L++) begin
      chk("midrst_valid", L, DW'(o_valid[L]), '0);
      chk("midrst_count", L, DW'(o_count[L]), '0);
      chk("midrst_data", L, o_data[L], '0);
    end
    clr_log();
    for (int L = 0; L < 2; L++) begin
      push(L, 32'hA1); push(L, 32'hA2); push(L, 32'hA3);
    end
    guard = 0;
    while (guard < 40 && !(idle(0) && idle(1))) begin
      step(2'b11, 1'b0, 1'b0);
      guard++;
    end
    step(2'b11, 1'b0, 1'b0);
    for (int L = 0; L < 2; L++) begin
      chk("resume_any", L, DW'(pn[L] >= 3), 32'd1);
      if (pn[L] >= 3) chk("resume_last", L, plog[L][pn[L]-1], 32'hA3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
